// File: rtl/fft_rx_pkg.sv
// fft_rx_pkg: receiver state type, default widths and block-exponent scaling.
// FFT_RX_SATURATE_EN makes scaling clamp out-of-range results instead of wrapping them.
package fft_rx_pkg;

    typedef enum logic [1:0] {IDLE, FRAME, DROP} rx_state_e;

    localparam int POINTS_DEF = 64;
    localparam int DATA_W_DEF = 8;
    localparam int EXP_W_DEF  = 6;
    localparam int OUT_W_DEF  = 12;

    // s > 0 shifts left, s < 0 shifts right arithmetically; result is sign-extended from out_w bits
    function automatic logic signed [63:0] fft_rx_scale(
        input logic signed [31:0] x,
        input int                 s,
        input int                 out_w
    );
        logic signed [63:0] w;
        logic signed [63:0] lim;
        logic               big;
        w   = {{32{x[31]}}, x};
        big = (s > 31) && (x != 0);
        w   = (s < 0) ? (w >>> ((s < -63) ? 63 : -s)) : (big ? 64'sd0 : (w <<< s));
        lim = 64'sd1 <<< (out_w - 1);
`ifdef FFT_RX_SATURATE_EN
        return big ? ((x < 0) ? -lim : lim - 64'sd1)
                   : ((w >= lim) ? lim - 64'sd1 : ((w < -lim) ? -lim : w));
`else
        return ((w + lim) & ((lim <<< 1) - 64'sd1)) - lim;
`endif
    endfunction

endpackage

// File: rtl/fft_rx_fifo.sv
// fft_rx_fifo: synchronous show-ahead FIFO; dout presents the oldest entry whenever not empty.
module fft_rx_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = count_q == '0;
        full    = count_q == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        dout    = mem_q[rd_q];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/fft_source_receiver.sv
// fft_source_receiver: checks framing of the FFT source stream, rescales by the block exponent, buffers and re-emits.
// FFT_RX_SATURATE_EN selects clamping of overflowing samples; otherwise they wrap to OUT_W bits.
module fft_source_receiver
    import fft_rx_pkg::*;
#(
    parameter int POINTS     = POINTS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int EXP_W      = EXP_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic signed [EXP_W-1:0]  in_exp,
    input  logic                     in_valid,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [1:0]               in_error,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_real,
    output logic signed [OUT_W-1:0]  out_imag,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    input  logic                     out_ready,
    output logic                     frame_err,
    output logic [7:0]               err_count,
    output logic [15:0]              frame_count
);

    localparam int IW = $clog2(POINTS);
    localparam int PW = 2 + 2 * OUT_W;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_e               state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [EXP_W-1:0] exp_q, exp_d, exp_use;
    logic                    warned_q, warned_d;
    logic                    frame_err_q, frame_err_d;
    logic                    pipe_valid_q, pipe_valid_d;
    logic                    ready_en_q;
    logic [7:0]              err_count_q, err_count_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [PW-1:0]           pipe_q, pipe_d, fifo_dout;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty, fifo_full, acc, fwd, last;

    always_comb begin
        in_ready      = !reset && ready_en_q && !fifo_full
                        && ((CW+1)'(fifo_count) + (CW+1)'(pipe_valid_q)) < (CW+1)'(FIFO_DEPTH);
        acc           = in_valid && in_ready;
        last          = idx_q == IW'(POINTS - 1);
        exp_use       = in_sop ? in_exp : exp_q;
        state_d       = state_q;
        idx_d         = idx_q;
        exp_d         = exp_q;
        warned_d      = acc ? 1'b0 : warned_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        fwd           = 1'b0;
        if (acc && in_error != 2'b00) begin
            frame_err_d = 1'b1;
            state_d     = in_eop ? IDLE : DROP;
        end else if (acc && in_sop) begin
            // a sop always restarts a frame; an eop on the same beat or an open frame is an error
            fwd         = 1'b1;
            frame_err_d = in_eop || state_q == FRAME;
            state_d     = in_eop ? IDLE : FRAME;
            idx_d       = IW'(1);
            exp_d       = in_exp;
        end else if (acc && state_q == FRAME) begin
            fwd           = 1'b1;
            idx_d         = idx_q + IW'(1);
            frame_err_d   = in_eop ? !last : last;
            frame_count_d = frame_count_q + 16'(in_eop && last);
            state_d       = in_eop ? IDLE : (last ? DROP : FRAME);
        end else if (acc && state_q == IDLE) begin
            frame_err_d = !warned_q;
            warned_d    = 1'b1;
        end else if (acc && in_eop) begin
            state_d = IDLE;
        end
        err_count_d  = err_count_q + 8'(frame_err_d && err_count_q != 8'hFF);
        pipe_valid_d = fwd;
        pipe_d       = {in_sop, in_eop,
                        OUT_W'(fft_rx_scale(32'(in_real), -int'(exp_use), OUT_W)),
                        OUT_W'(fft_rx_scale(32'(in_imag), -int'(exp_use), OUT_W))};
        {out_sop, out_eop, out_real, out_imag} = fifo_empty ? '0 : fifo_dout;
        out_valid    = !fifo_empty;
        frame_err    = frame_err_q;
        err_count    = err_count_q;
        frame_count  = frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            exp_q         <= '0;
            warned_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            pipe_valid_q  <= 1'b0;
            ready_en_q    <= 1'b0;
            err_count_q   <= '0;
            frame_count_q <= '0;
            pipe_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            exp_q         <= exp_d;
            warned_q      <= warned_d;
            frame_err_q   <= frame_err_d;
            pipe_valid_q  <= pipe_valid_d;
            ready_en_q    <= 1'b1;
            err_count_q   <= err_count_d;
            frame_count_q <= frame_count_d;
            pipe_q        <= pipe_d;
        end
    end

    fft_rx_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_valid_q),
        .pop   (out_valid && out_ready),
        .din   (pipe_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_fft_source_receiver.sv
// tb_fft_source_receiver: directed framing, scaling, back-pressure and reset checks for fft_source_receiver.
module tb_fft_source_receiver;

    typedef struct {
        int re;
        int im;
        bit sop;
        bit eop;
        int cyc;
    } smp_t;

`ifdef FFT_RX_SATURATE_EN
    localparam int OVF_EXP = 2047;
`else
    localparam int OVF_EXP = -64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_real = '0;
    logic [7:0]  in_imag = '0;
    logic [5:0]  in_exp = '0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;
    logic [1:0]  in_error = '0;
    logic        in_ready;
    logic [11:0] out_real, out_imag;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready = 1'b1;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [15:0] frame_count;

    smp_t q[$];
    int   acc_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   cyc = 0;

    fft_source_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .in_exp      (in_exp),
        .in_valid    (in_valid),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_error    (in_error),
        .in_ready    (in_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_ready   (out_ready),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) q.push_back('{$signed(out_real), $signed(out_imag), out_sop, out_eop, cyc});
        if (frame_err) pulses++;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] r, input logic [7:0] im, input logic [5:0] e,
                        input logic s, input logic eo, input logic [1:0] er);
        int   t;
        logic ok;
        t = 0;
        in_real = r;
        in_imag = im;
        in_exp = e;
        in_sop = s;
        in_eop = eo;
        in_error = er;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        if (!ok) begin
            errors++;
            $error("FAIL ready_timeout: observed in_ready 0 expected 1");
        end
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        in_error = 2'b00;
    endtask

    task automatic send_frame(input int n, input int eop_i, input int err_i, input logic [5:0] e,
                              input logic [7:0] r0, input logic [7:0] i0);
        for (int i = 0; i < n; i++)
            beat(i == 0 ? r0 : 8'(i - 32), i == 0 ? i0 : 8'(i), e, i == 0, i == eop_i,
                 i == err_i ? 2'b01 : 2'b00);
    endtask

    function automatic smp_t at(input int i);
        smp_t s;
        s = '{32'hDEAD, 0, 1'b0, 1'b0, 0};
        if (i < q.size()) s = q[i];
        return s;
    endfunction

    function automatic int clean_bad(input int base);
        int   bad;
        smp_t s;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            s = at(base + i);
            if (s.re != i - 32 || s.im != i || s.sop != (i == 0) || s.eop != (i == 63)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int   qb, pb, ab;
        smp_t s0, s1;
        tick(3);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sop", out_sop, 0);
        check("rst_out_eop", out_eop, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_frame_count", frame_count, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_held", in_ready, 0);
        tick(1);
        check("rst_ready_rise", in_ready, 1);

        qb = q.size();
        pb = pulses;
        ab = acc_cyc.size();
        send_frame(64, 63, -1, 6'd0, 8'hE0, 8'h00);
        tick(10);
        s0 = at(qb);
        s1 = at(qb + 63);
        check("clean_count", q.size() - qb, 64);
        check("clean_data", clean_bad(qb), 0);
        check("clean_latency", s0.cyc - acc_cyc[ab], 2);
        check("clean_rate", s1.cyc - s0.cyc, 63);
        check("clean_frames", frame_count, 1);
        check("clean_no_err", pulses - pb, 0);

        qb = q.size();
        send_frame(64, 63, -1, 6'h3D, 8'h7F, 8'h80);
        tick(10);
        s0 = at(qb);
        check("scale_l3_re", s0.re, 1016);
        check("scale_l3_im", s0.im, -1024);
        qb = q.size();
        send_frame(64, 63, -1, 6'd2, 8'hFB, 8'h00);
        tick(10);
        s0 = at(qb);
        check("scale_r2_re", s0.re, -2);
        qb = q.size();
        send_frame(64, 63, -1, 6'h3A, 8'h7F, 8'h00);
        tick(10);
        s0 = at(qb);
        check("scale_ovf_re", s0.re, OVF_EXP);
        check("scale_frames", frame_count, 4);

        pb = pulses;
        send_frame(11, 10, -1, 6'd0, 8'hE0, 8'h00);
        tick(4);
        check("early_pulse", pulses - pb, 1);
        check("early_err_count", err_count, 1);
        check("early_frames", frame_count, 4);
        qb = q.size();
        send_frame(64, 63, -1, 6'd0, 8'hE0, 8'h00);
        tick(10);
        check("recover_frames", frame_count, 5);
        check("recover_data", clean_bad(qb), 0);

        pb = pulses;
        qb = q.size();
        send_frame(20, -1, -1, 6'd0, 8'hE0, 8'h00);
        send_frame(64, 63, -1, 6'd0, 8'hE0, 8'h00);
        tick(10);
        s0 = at(qb + 20);
        check("midsop_pulse", pulses - pb, 1);
        check("midsop_err_count", err_count, 2);
        check("midsop_frames", frame_count, 6);
        check("midsop_count", q.size() - qb, 84);
        check("midsop_sop", s0.sop, 1);
        check("midsop_data", clean_bad(qb + 20), 0);

        qb = q.size();
        ab = acc_cyc.size();
        out_ready = 1'b0;
        fork
            send_frame(64, 63, -1, 6'd0, 8'hE0, 8'h00);
            begin
                tick(30);
                check("bp_accepted", acc_cyc.size() - ab, 16);
                check("bp_ready_low", in_ready, 0);
                check("bp_head_re", $signed(out_real), -32);
                check("bp_head_sop", out_sop, 1);
                out_ready = 1'b1;
            end
        join
        tick(30);
        check("bp_count", q.size() - qb, 64);
        check("bp_data", clean_bad(qb), 0);
        check("bp_frames", frame_count, 7);

        pb = pulses;
        qb = q.size();
        for (int i = 0; i < 3; i++) beat(8'd1, 8'd1, 6'd0, 1'b0, 1'b0, 2'b00);
        tick(4);
        check("idle_pulse", pulses - pb, 1);
        check("idle_err_count", err_count, 3);
        check("idle_dropped", q.size() - qb, 0);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        pb = pulses;
        qb = q.size();
        send_frame(64, 63, 5, 6'd0, 8'hE0, 8'h00);
        tick(10);
        check("inerr_pulse", pulses - pb, 1);
        check("inerr_err_count", err_count, 1);
        check("inerr_frames", frame_count, 0);
        check("inerr_count", q.size() - qb, 5);
        out_ready = 1'b0;
        send_frame(12, -1, -1, 6'd0, 8'hE0, 8'h00);
        tick(4);
        check("prerst_valid", out_valid, 1);
        reset = 1'b1;
        tick(2);
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_frames", frame_count, 0);
        check("midrst_frame_err", frame_err, 0);
        reset = 1'b0;
        #1;
        check("midrst_ready_held", in_ready, 0);
        tick(1);
        check("midrst_ready_rise", in_ready, 1);
        out_ready = 1'b1;
        qb = q.size();
        pb = pulses;
        send_frame(64, 63, -1, 6'd0, 8'hE0, 8'h00);
        tick(10);
        check("postrst_count", q.size() - qb, 64);
        check("postrst_data", clean_bad(qb), 0);
        check("postrst_frames", frame_count, 1);
        check("postrst_no_err", pulses - pb, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_source_receiver.md
# fft_source_receiver

Consumes the Avalon-ST source stream of the OFDM FFT/IFFT core (block-floating-point real/imag/exponent with sop/eop/valid and ready back-pressure) and turns it into fixed-scale samples for the downstream OFDM chain. It drives the core's source_ready, checks frame framing, and applies the per-frame exponent to each sample. It buffers results in a small FIFO and re-emits them as a clean sop/eop/valid/ready stream with frame-error reporting.

## Interface
Parameters:
- POINTS, 64, FFT length; samples per frame.
- DATA_W, 8, width of in_real/in_imag.
- EXP_W, 6, width of in_exp (signed).
- OUT_W, 12, width of out_real/out_imag (signed).
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_real / in_imag  in  DATA_W  signed FFT source data.
- in_exp  in  EXP_W  signed block exponent; latched on the sop beat.
- in_valid, in_sop, in_eop  in  1  FFT source handshake and framing.
- in_error  in  2  FFT source_error; nonzero marks the beat bad.
- in_ready  out  1  drives the FFT source_ready, with ready latency 0.
- out_real / out_imag  out  OUT_W  scaled samples.
- out_valid, out_sop, out_eop  out  1  downstream stream.
- out_ready  in  1  downstream back-pressure.
- frame_err  out  1  one-cycle pulse per detected framing/error event.
- err_count  out  8  saturating count of frame_err pulses.
- frame_count  out  16  wrapping count of correctly framed frames (eop at index POINTS-1, no error).

## Operation
- A beat is accepted when in_valid && in_ready. Only accepted beats affect state.
- State machine (state enum defined in the package):
  - IDLE: waits for a sop beat.
    - An accepted sop moves to FRAME, sets idx=1 and latches in_exp. If that beat also carries eop, it is an early eop: frame_err, return to IDLE.
    - Non-sop beats are discarded, except for one frame_err pulse on the first discarded beat after IDLE is entered.
  - FRAME: idx increments per accepted beat.
    - eop at idx==POINTS-1: frame_count++, go to IDLE.
    - eop earlier than that: frame_err, go to IDLE.
    - A beat at idx==POINTS-1 without eop: frame_err, go to DROP.
    - A sop mid-frame: frame_err; that beat starts a new frame (idx=1, re-latch exponent).
  - DROP: discard beats until an accepted eop (go to IDLE) or sop (same as the IDLE sop path).
  - A beat with nonzero in_error in any state: frame_err, beat discarded, go to DROP. If the beat also has eop, go to IDLE instead.
- Forwarding:
  - Beats accepted in IDLE (sop) or FRAME are forwarded.
  - out_sop marks forwarded sop beats; out_eop marks forwarded eop beats.
  - Forwarded data are never retracted; downstream treats a frame with no matching out_eop before the next out_sop as bad.
- Scaling: s = -exp, as a signed value.
  - s ≥ 0: sample = sign_extend(x) << s.
  - s < 0: sample = sign_extend(x) >>> (-s), arithmetic shift, truncating toward −∞.
  - The result fits OUT_W as described under Configuration.
- in_ready = (fifo_count + pipe_valid) < FIFO_DEPTH, combinational, and low while reset is high.
- Simultaneous FIFO push and pop in one cycle are both performed; the count is unchanged.

## Timing
- Reset values:
  - in_ready=0, which rises the cycle after reset deasserts.
  - out_valid, out_sop, out_eop, frame_err = 0.
  - err_count=0, frame_count=0, state=IDLE, FIFO flushed.
- A reset mid-frame discards the partial frame and all buffered samples.
- Latency: one register stage for scaling plus a show-ahead FIFO. An accepted beat appears on out_* two cycles later when the FIFO is empty and out_ready=1.
- Throughput: one beat per cycle sustained while out_ready=1.
- Output stability: out_* hold stable while out_valid && !out_ready.
- frame_err asserts the cycle after the offending beat is accepted.
- err_count saturates at 255. frame_count wraps modulo 2^16.

## Configuration
- FFT_RX_SATURATE_EN defined: a left-shifted result outside the OUT_W range clamps to +(2^(OUT_W-1)-1) or −2^(OUT_W-1).
- FFT_RX_SATURATE_EN undefined: the result is truncated to its low OUT_W bits (wraps).

## Structure
- Package fft_rx_pkg holds:
  - the state enum (IDLE, FRAME, DROP);
  - default POINTS/DATA_W/EXP_W/OUT_W constants;
  - the shift/saturate function.
- Sub-module fft_rx_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH. Its ports are push, pop, din, dout, count, empty and full.
  - Payload per entry is {sop, eop, real, imag}.

## Test plan
- Clean frame: 64 beats, exp=0, in_real=idx-32, out_ready=1 → 64 outputs with values equal to the inputs, out_sop on beat 0, out_eop on beat 63, frame_count=1, no frame_err.
- Scaling: exp=-3 with in_real=0x7F and exp=+2 with in_real=-5 → 1016 and -2. exp=-6 with in_real=0x7F gives 8128, which overflows OUT_W=12: it saturates to 2047 with FFT_RX_SATURATE_EN defined, and wraps to -64 without it.
- Early eop at beat 10 → frame_err pulse, err_count=1, frame_count=0. The next clean frame is counted.
- Mid-frame sop at beat 20, followed by a full 64-beat frame → one frame_err. The second frame is forwarded with out_sop, and frame_count=1.
- Back-pressure: out_ready held low for 30 cycles during a frame → in_ready falls once 16 entries are pending. No beat is lost or duplicated, and the output order is preserved.
- in_error=2'b01 on beat 5, then reset asserted on beat 40 of a later frame → DROP until eop and err_count=1. Reset clears all outputs and counters, and in_ready returns the cycle after reset deasserts.
